// File: rtl/rst_release_seq.sv
// rst_release_seq: turns the raw asynchronous system reset into a synchronized reset
// and a set of per-domain resets that are released one after another, STAGGER cycles
// apart. Once every domain is released it raises rst_done and counts uptime.
//
// Optional feature (macro RST_SEQ_SW_RST_EN): a software reset request re-runs the
// domain release sequence without touching the synchronizer. It adds the
// sw_rst_req / sw_rst_active ports and the SWRST state.
module rst_release_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_DOMAINS   = 3,
  parameter int STAGGER       = 4,
  parameter int UPTIME_W      = 16,
  parameter int SW_RST_CYCLES = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_resetn,
`ifdef RST_SEQ_SW_RST_EN
  input  logic                   sw_rst_req,
  output logic                   sw_rst_active,
`endif
  output logic                   rst_sync_n,
  output logic [NUM_DOMAINS-1:0] dom_resetn,
  output logic                   rst_done,
  output logic [UPTIME_W-1:0]    uptime
);

  // One counter serves both the stagger interval and the software reset hold.
  localparam int CNT_MAX = (STAGGER > SW_RST_CYCLES) ? STAGGER : SW_RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Four bits cover every legal domain index (NUM_DOMAINS <= 8).
  localparam int IDX_W   = 4;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_STAGGER = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
`ifdef RST_SEQ_SW_RST_EN
  localparam logic [1:0] ST_SWRST   = 2'd3;
`endif

  logic [SYNC_STAGES-1:0] sync_q;

  logic [1:0]             state_q,  state_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic [IDX_W-1:0]       idx_q,    idx_d;
  logic [NUM_DOMAINS-1:0] dom_q,    dom_d;
  logic                   done_q,   done_d;
  logic [UPTIME_W-1:0]    uptime_q, uptime_d;
`ifdef RST_SEQ_SW_RST_EN
  logic                   swact_q,  swact_d;
`endif

  // Reset synchronizer: asserts with sys_resetn, releases after SYNC_STAGES edges.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples
      // the pre-edge value; a blocking shift would collapse the chain into one flop.
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

  // Sequencer next-state: HOLD until synchronized, stagger the releases, then DONE.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dom_d    = dom_q;
    done_d   = done_q;
    uptime_d = uptime_q;
`ifdef RST_SEQ_SW_RST_EN
    swact_d  = swact_q;
`endif

    case (state_q)
      ST_HOLD: begin
        if (rst_sync_n) begin
          state_d = ST_STAGGER;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      ST_STAGGER: begin
        if (cnt_q == CNT_W'(STAGGER - 1)) begin
          cnt_d = '0;
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (idx_q == IDX_W'(i)) dom_d[i] = 1'b1;
          end
          if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // First DONE cycle raises rst_done with uptime still 0; count after that.
        if (!done_q) begin
          done_d = 1'b1;
        end else if (uptime_q != '1) begin
          uptime_d = uptime_q + UPTIME_W'(1);
        end
      end

`ifdef RST_SEQ_SW_RST_EN
      ST_SWRST: begin
        // The edge that leaves SWRST is the new release reference, like leaving HOLD.
        if (cnt_q == CNT_W'(SW_RST_CYCLES - 1)) begin
          state_d = ST_STAGGER;
          cnt_d   = '0;
          idx_d   = '0;
          swact_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      default: begin
        state_d = ST_HOLD;
      end
    endcase

`ifdef RST_SEQ_SW_RST_EN
    // A software request is honoured only once the sequence has started; it drops
    // every domain and restarts the hold counter.
    if (sw_rst_req && (state_q == ST_STAGGER || state_q == ST_DONE)) begin
      state_d  = ST_SWRST;
      cnt_d    = '0;
      idx_d    = '0;
      dom_d    = '0;
      done_d   = 1'b0;
      uptime_d = '0;
      swact_d  = 1'b1;
    end
`endif
  end

  // Sequencer registers; an asynchronous reset drops every output at once.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      dom_q    <= '0;
      done_q   <= 1'b0;
      uptime_q <= '0;
`ifdef RST_SEQ_SW_RST_EN
      swact_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dom_q    <= dom_d;
      done_q   <= done_d;
      uptime_q <= uptime_d;
`ifdef RST_SEQ_SW_RST_EN
      swact_q  <= swact_d;
`endif
    end
  end

  assign dom_resetn = dom_q;
  assign rst_done   = done_q;
  assign uptime     = uptime_q;
`ifdef RST_SEQ_SW_RST_EN
  assign sw_rst_active = swact_q;
`endif

endmodule
